sqrt_sum_pipe: RTL and testbench

//  Fully pipelined sum of integer square roots over N_CH unsigned channels:
//  res = sum over i of (arg_mask[i] ? floor(sqrt(arg[i])) : 0).

---
 rtl/sqrt_sum_pipe.sv | 154 +++++++++++++++
 tb/tb_sqrt_sum_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_sum_pipe.sv
// Pipelined sum of masked integer square roots over N_CH channels.
// Latency is WIDTH/2 + $clog2(N_CH) + 1 cycles; data registers load only with their valid.
module sqrt_sum_pipe #(
   parameter int WIDTH = 32,
   parameter int N_CH  = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               arg_vld,
   input  logic [N_CH*WIDTH-1:0]              arg,
   input  logic [N_CH-1:0]                    arg_mask,
   output logic                               res_vld,
   output logic [WIDTH/2+$clog2(N_CH)-1:0]    res
);

   localparam int SQ_W   = WIDTH / 2;
   localparam int TREE   = $clog2(N_CH);
   localparam int RES_W  = SQ_W + TREE;
   localparam int RW     = SQ_W + 2;
   localparam int TW     = SQ_W + 4;
   localparam int TREE_N = (TREE > 0) ? TREE : 1;

   // index 0 of each chain is the module input, index s+1 is stage s's register
   logic [SQ_W:0]      vld_chain;
   logic [N_CH-1:0]    mask_c [SQ_W+1];
   logic [RW-1:0]      rem_c  [SQ_W+1][N_CH];
   logic [SQ_W-1:0]    root_c [SQ_W+1][N_CH];
   logic [WIDTH-1:0]   rad_c  [SQ_W+1][N_CH];

   logic [SQ_W-1:0]    sq_vld_q, sq_vld_d;
   logic [N_CH-1:0]    mask_q [SQ_W], mask_d [SQ_W];
   logic [RW-1:0]      rem_q  [SQ_W][N_CH], rem_d  [SQ_W][N_CH];
   logic [SQ_W-1:0]    root_q [SQ_W][N_CH], root_d [SQ_W][N_CH];
   logic [WIDTH-1:0]   rad_q  [SQ_W][N_CH], rad_d  [SQ_W][N_CH];

   logic [RES_W-1:0]   node   [TREE+1][N_CH+1];
   logic [RES_W-1:0]   tree_q [TREE_N][N_CH], tree_d [TREE_N][N_CH];
   logic [TREE_N-1:0]  tr_vld_q, tr_vld_d;
   logic [TREE_N:0]    tr_chain;

   logic               res_vld_q, res_vld_d;
   logic [RES_W-1:0]   res_q, res_d;

   always_comb begin : sqrt_chain
      vld_chain = {sq_vld_q, arg_vld};
      mask_c[0] = arg_mask;
      for (int c = 0; c < N_CH; c++) begin
         rem_c[0][c]  = '0;
         root_c[0][c] = '0;
         rad_c[0][c]  = arg[c*WIDTH +: WIDTH];
      end
      for (int s = 0; s < SQ_W; s++) begin
         mask_c[s+1] = mask_q[s];
         for (int c = 0; c < N_CH; c++) begin
            rem_c[s+1][c]  = rem_q[s][c];
            root_c[s+1][c] = root_q[s][c];
            rad_c[s+1][c]  = rad_q[s][c];
         end
      end
   end

   // restoring step: bring down two radicand bits, try subtracting 4*root+1
   always_comb begin : sqrt_step
      logic [TW-1:0] t;
      logic [TW-1:0] trial;
      sq_vld_d = vld_chain[SQ_W-1:0];
      for (int s = 0; s < SQ_W; s++) begin
         mask_d[s] = mask_c[s];
         for (int c = 0; c < N_CH; c++) begin
            t     = {rem_c[s][c], rad_c[s][c][WIDTH-1 -: 2]};
            trial = {2'b00, root_c[s][c], 2'b01};
            if (t >= trial) begin
               rem_d[s][c]  = RW'(t - trial);
               root_d[s][c] = SQ_W'({root_c[s][c], 1'b1});
            end else begin
               rem_d[s][c]  = RW'(t);
               root_d[s][c] = SQ_W'({root_c[s][c], 1'b0});
            end
            rad_d[s][c] = rad_c[s][c] << 2;
         end
      end
   end

   // unused tail slots stay zero, so an odd leftover passes through as x + 0
   always_comb begin : add_tree
      for (int l = 0; l <= TREE; l++) begin
         for (int j = 0; j <= N_CH; j++) begin
            node[l][j] = '0;
         end
      end
      for (int c = 0; c < N_CH; c++) begin
         node[0][c] = mask_c[SQ_W][c] ? RES_W'(root_c[SQ_W][c]) : '0;
      end
      for (int l = 1; l <= TREE; l++) begin
         for (int j = 0; j < N_CH; j++) begin
            node[l][j] = tree_q[l-1][j];
         end
      end
      for (int l = 0; l < TREE_N; l++) begin
         for (int j = 0; j < N_CH; j++) begin
            tree_d[l][j] = '0;
         end
      end
      for (int l = 0; l < TREE; l++) begin
         for (int j = 0; j < (N_CH + 1) / 2; j++) begin
            tree_d[l][j] = node[l][2*j] + node[l][2*j+1];
         end
      end
      tr_chain  = {tr_vld_q, vld_chain[SQ_W]};
      tr_vld_d  = tr_chain[TREE_N-1:0];
      res_vld_d = tr_chain[TREE];
      res_d     = node[TREE][0];
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < SQ_W; s++) begin
         if (vld_chain[s]) begin
            mask_q[s] <= mask_d[s];
            for (int c = 0; c < N_CH; c++) begin
               rem_q[s][c]  <= rem_d[s][c];
               root_q[s][c] <= root_d[s][c];
               rad_q[s][c]  <= rad_d[s][c];
            end
         end
      end
      for (int l = 0; l < TREE; l++) begin
         if (tr_chain[l]) begin
            for (int j = 0; j < N_CH; j++) begin
               tree_q[l][j] <= tree_d[l][j];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sq_vld_q  <= '0;
         tr_vld_q  <= '0;
         res_vld_q <= 1'b0;
         res_q     <= '0;
      end else begin
         sq_vld_q  <= sq_vld_d;
         tr_vld_q  <= tr_vld_d;
         res_vld_q <= res_vld_d;
         if (res_vld_d) begin
            res_q <= res_d;
         end
      end
   end

   assign res_vld = res_vld_q;
   assign res     = res_q;

endmodule

// File: tb/tb_sqrt_sum_pipe.sv
// Directed and table-driven checks for sqrt_sum_pipe (32x3 instance) plus an 8x5 instance.
module tb_sqrt_sum_pipe;

   localparam int W   = 32;
   localparam int N   = 3;
   localparam int LAT = 19;
   localparam int RW  = 18;

   logic            clk = 1'b0;
   logic            rst;
   logic            arg_vld;
   logic [N*W-1:0]  arg;
   logic [N-1:0]    arg_mask;
   logic            res_vld;
   logic [RW-1:0]   res;

   logic            arg_vld2;
   logic [39:0]     arg2;
   logic [4:0]      mask2;
   logic            res_vld2;
   logic [6:0]      res2;

   always #5 clk = ~clk;

   sqrt_sum_pipe #(.WIDTH(32), .N_CH(3)) u_dut (
      .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg(arg), .arg_mask(arg_mask),
      .res_vld(res_vld), .res(res)
   );

   sqrt_sum_pipe #(.WIDTH(8), .N_CH(5)) u_dut2 (
      .clk(clk), .rst(rst), .arg_vld(arg_vld2), .arg(arg2), .arg_mask(mask2),
      .res_vld(res_vld2), .res(res2)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic longint isqrt_ref(input longint x);
      longint r;
      r = longint'($floor($sqrt(real'(x))));
      while (r * r > x) r--;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   // expected output delay line, fed from what the driver applies each cycle
   logic    exp_vld_in;
   longint  exp_res_in;
   logic    dl_vld [LAT];
   longint  dl_res [LAT];
   longint  last_res;
   bit      mon_en;

   task automatic clear_model();
      for (int i = 0; i < LAT; i++) begin
         dl_vld[i] = 1'b0;
         dl_res[i] = 0;
      end
      last_res = 0;
   endtask

   always @(negedge rst) clear_model();

   always @(posedge clk) begin
      if (!rst) clear_model();
      else begin
         for (int i = LAT - 1; i > 0; i--) begin
            dl_vld[i] = dl_vld[i-1];
            dl_res[i] = dl_res[i-1];
         end
         dl_vld[0] = exp_vld_in;
         dl_res[0] = exp_res_in;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (dl_vld[LAT-1]) last_res = dl_res[LAT-1];
         check("mon_res_vld", res_vld, dl_vld[LAT-1]);
         check("mon_res", res, last_res);
      end
   end

   task automatic drive(input logic v, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [2:0] m, input longint e);
      arg_vld    = v;
      arg        = {a2, a1, a0};
      arg_mask   = m;
      exp_vld_in = v;
      exp_res_in = e;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, $urandom, 3'($urandom), 0);
   endtask

   task automatic drive_rand();
      logic [31:0] a0, a1, a2;
      logic [2:0]  m;
      longint      e;
      a0 = $urandom; a1 = $urandom; a2 = $urandom;
      if ($urandom_range(0, 3) == 0) a0 = a0 >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) a1 = a1 >> $urandom_range(0, 31);
      m = 3'($urandom);
      e = (m[0] ? isqrt_ref(longint'(a0)) : 0) + (m[1] ? isqrt_ref(longint'(a1)) : 0) +
          (m[2] ? isqrt_ref(longint'(a2)) : 0);
      drive(1'b1, a0, a1, a2, m, e);
   endtask

   typedef struct {
      logic [31:0] a0;
      logic [31:0] a1;
      logic [31:0] a2;
      logic [2:0]  mask;
      longint      exp;
   } vec_t;

   vec_t vecs [8];
   int   lat;

   initial begin
      vecs[0] = '{32'd16,         32'd9,          32'd4,  3'b111, 9};
      vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 3'b111, 196605};
      vecs[2] = '{32'd0,          32'd1,          32'd2,  3'b111, 2};
      vecs[3] = '{32'd100,        32'd49,         32'd25, 3'b101, 15};
      vecs[4] = '{32'd100,        32'd49,         32'd25, 3'b000, 0};
      vecs[5] = '{32'd4294836225, 32'd4294836224, 32'd1,  3'b111, 131070};
      vecs[6] = '{32'd15,         32'd24,         32'd25, 3'b111, 12};
      vecs[7] = '{32'd16,         32'd9,          32'd4,  3'b010, 3};

      rst = 1'b0; mon_en = 1'b0;
      arg_vld = 1'b0; arg = '0; arg_mask = '0; exp_vld_in = 1'b0; exp_res_in = 0;
      arg_vld2 = 1'b0; arg2 = '0; mask2 = '0;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check("rst_res_vld", res_vld, 0);
      check("rst_res", res, 0);
      check("rst_res_vld2", res_vld2, 0);
      check("rst_res2", res2, 0);
      rst = 1'b1;
      mon_en = 1'b1;

      // single set: measure latency and pulse width
      drive(1'b1, 32'd16, 32'd9, 32'd4, 3'b111, 9);
      arg_vld = 1'b0; exp_vld_in = 1'b0; exp_res_in = 0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (res_vld === 1'b1) begin
            lat = i;
            break;
         end
      end
      check("latency", lat, LAT);
      if (lat > 0) begin
         check("single_res", res, 9);
         @(negedge clk);
         check("single_pulse_width", res_vld, 0);
      end
      @(posedge clk); #1;
      idle(25);

      for (int i = 0; i < 8; i++) drive(1'b1, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].mask, vecs[i].exp);
      idle(25);

      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) < 6) drive_rand();
         else idle(1);
      end
      idle(25);

      // reset mid-flight
      for (int i = 0; i < 5; i++) drive_rand();
      idle(3);
      rst = 1'b0;
      #1;
      check("midrst_res_vld", res_vld, 0);
      check("midrst_res", res, 0);
      idle(1);
      rst = 1'b1;
      idle(25);
      drive(1'b1, 32'd1000000, 32'd81, 32'd7, 3'b111, 1011);
      idle(25);

      // 8-bit x 5-channel instance, back-to-back sets
      arg_vld2 = 1'b1;
      arg2 = {5{8'hFF}};
      mask2 = 5'h1F;
      @(posedge clk); #1;
      arg2 = {8'd16, 8'd15, 8'd8, 8'd4, 8'd3};
      @(posedge clk); #1;
      arg_vld2 = 1'b0;
      arg2 = {$urandom, 8'($urandom)};
      mask2 = 5'($urandom);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("w8_early_vld", res_vld2, 0);
      @(posedge clk);
      @(negedge clk);
      check("w8_max_vld", res_vld2, 1);
      check("w8_max_res", res2, 75);
      @(negedge clk);
      check("w8_mix_vld", res_vld2, 1);
      check("w8_mix_res", res2, 12);
      @(negedge clk);
      check("w8_after_vld", res_vld2, 0);
      check("w8_hold_res", res2, 12);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
